// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter
// Four-digit BCD up/down counter that advances once per rate-divider tick.
// A push-button toggles run/pause, and a synchronous load presets the count.
//
// Ports:
//   ClockIn      - system clock; all state changes on its rising edge
//   Clear_b      - asynchronous active-low reset
//   Tick         - one-cycle enable pulse from the rate divider
//   StartStop_n  - raw active-low push-button, asynchronous to ClockIn
//   Down         - count direction (0 = up, 1 = down)
//   Load         - synchronous preset strobe (highest priority)
//   LoadValue    - preset value, four BCD digits, [3:0] = ones
//   Digits       - current count, four BCD digits, [3:0] = ones
//   Running      - 1 while counting is enabled
//   Wrap         - one-cycle pulse alongside a rolled-over count
module bcd_tick_counter #(
    parameter logic START_RUNNING = 1'b0
) (
    input  logic        ClockIn,
    input  logic        Clear_b,
    input  logic        Tick,
    input  logic        StartStop_n,
    input  logic        Down,
    input  logic        Load,
    input  logic [15:0] LoadValue,
    output logic [15:0] Digits,
    output logic        Running,
    output logic        Wrap
);

    typedef enum logic {
        PAUSED = 1'b0,
        RUN    = 1'b1
    } run_state_t;

    localparam run_state_t RESET_STATE = START_RUNNING ? RUN : PAUSED;

    run_state_t  state_q, state_d;
    logic        s1_q, s2_q, p_q;
    logic        press;
    logic [15:0] digits_q, digits_d;
    logic        wrap_q, wrap_d;
    logic [16:0] step;

    // Any digit above 9 saturates to 9 so the count never holds a non-BCD code.
    function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (v[i*4 +: 4] > 4'd9) begin
                r[i*4 +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    // Returns {rollover, next value}. The carry/borrow ripples from the ones
    // digit upward; a carry out of the thousands digit is the rollover.
    function automatic logic [16:0] bcd_step(input logic [15:0] v, input logic dn);
        logic [15:0] r;
        logic        c;
        logic [3:0]  d;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = v[i*4 +: 4];
            if (c) begin
                if (!dn) begin
                    if (d >= 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                        c = 1'b1;
                    end else begin
                        r[i*4 +: 4] = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        r[i*4 +: 4] = 4'd9;
                        c = 1'b1;
                    end else begin
                        r[i*4 +: 4] = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return {c, r};
    endfunction

    // Synchronizer and edge detector: released key (1) is the reset value so
    // deasserting reset alone never looks like a press.
    always_ff @(posedge ClockIn or negedge Clear_b) begin
        if (!Clear_b) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            p_q  <= 1'b1;
        end else begin
            s1_q <= StartStop_n;
            s2_q <= s1_q;
            p_q  <= s2_q;
        end
    end

    assign press = p_q & ~s2_q;

    // Run/pause FSM state register
    always_ff @(posedge ClockIn or negedge Clear_b) begin
        if (!Clear_b) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PAUSED:  if (press) state_d = RUN;
            RUN:     if (press) state_d = PAUSED;
            default: state_d = RESET_STATE;
        endcase
    end

    // Count update: load beats tick; counting looks at the pre-toggle state.
    assign step = bcd_step(digits_q, Down);

    always_comb begin
        digits_d = digits_q;
        wrap_d   = 1'b0;
        if (Load) begin
            digits_d = clamp_bcd(LoadValue);
        end else if (Tick && (state_q == RUN)) begin
            digits_d = step[15:0];
            wrap_d   = step[16];
        end
    end

    always_ff @(posedge ClockIn or negedge Clear_b) begin
        if (!Clear_b) begin
            digits_q <= 16'h0000;
            wrap_q   <= 1'b0;
        end else begin
            digits_q <= digits_d;
            wrap_q   <= wrap_d;
        end
    end

    assign Digits  = digits_q;
    assign Running = (state_q == RUN);
    assign Wrap    = wrap_q;

endmodule
